// File: rtl/trace_pkg.sv
// ============================================================================
// trace_pkg : shared state encoding, trace record layout and packing helper
// Rev 1.0
// ============================================================================
`default_nettype none

package trace_pkg;

  localparam int REC_W  = 72;
  localparam int DST_W  = 4;
  localparam int WORD_W = 16;

  localparam int HLT_BIT   = 71;
  localparam int MWR_BIT   = 70;
  localparam int MRD_BIT   = 69;
  localparam int RWE_BIT   = 68;
  localparam int DST_LSB   = 64;
  localparam int PC_LSB    = 48;
  localparam int RDATA_LSB = 32;
  localparam int MADDR_LSB = 16;
  localparam int MDATA_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  typedef logic [REC_W-1:0] rec_t;

  function automatic rec_t pack_rec(
    input logic              hlt,
    input logic              mem_wr,
    input logic              mem_rd,
    input logic              reg_we,
    input logic [DST_W-1:0]  reg_dst,
    input logic [WORD_W-1:0] pc,
    input logic [WORD_W-1:0] reg_data,
    input logic [WORD_W-1:0] mem_addr,
    input logic [WORD_W-1:0] mem_data
  );
    rec_t r;
    r                      = '0;
    r[HLT_BIT]             = hlt;
    r[MWR_BIT]             = mem_wr;
    r[MRD_BIT]             = mem_rd;
    r[RWE_BIT]             = reg_we;
    r[DST_LSB+:DST_W]      = reg_dst;
    r[PC_LSB+:WORD_W]      = pc;
    r[RDATA_LSB+:WORD_W]   = reg_data;
    r[MADDR_LSB+:WORD_W]   = mem_addr;
    r[MDATA_LSB+:WORD_W]   = mem_data;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/perf_trace_unit_if.sv
// ============================================================================
// perf_trace_unit_if : retire-event inputs and trace drain handshake
// Rev 1.0
// ============================================================================
`default_nettype none

interface perf_trace_unit_if;
  import trace_pkg::*;

  logic [15:0] pc;
  logic        reg_we;
  logic [3:0]  reg_dst;
  logic [15:0] reg_data;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        hlt;
  logic        out_valid;
  logic        out_ready;
  rec_t        out_rec;

  modport master (
    output pc, reg_we, reg_dst, reg_data, mem_rd, mem_wr, mem_addr, mem_data, hlt,
    output out_ready,
    input  out_valid, out_rec
  );

  modport slave (
    input  pc, reg_we, reg_dst, reg_data, mem_rd, mem_wr, mem_addr, mem_data, hlt,
    input  out_ready,
    output out_valid, out_rec
  );

endinterface

`default_nettype wire

// File: rtl/trace_fifo.sv
// ============================================================================
// trace_fifo : flop-based record FIFO; output is read from storage registers
// Rev 1.0
// ============================================================================
`default_nettype none

module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 72
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             flush,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [WIDTH-1:0] din,
  output logic      [WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign empty  = (r_count == '0);
  assign full   = (r_count == (AW+1)'(DEPTH));
  // A push into a full FIFO is only accepted when a pop frees the slot.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign dout   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/perf_trace_unit.sv
// ============================================================================
// perf_trace_unit : run-state FSM, perf counters, watchdog and trace capture
// Rev 1.0
// ============================================================================
`default_nettype none

module perf_trace_unit
  import trace_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        en,
  input  wire logic        clear,
  perf_trace_unit_if.slave trace,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt,
  output logic [15:0]      drop_cnt,
  output logic             overflow,
  output logic             done,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] c_wd_limit = CNT_W'(MAX_CYCLES - 1);

  state_t r_state;
  state_t w_next;
  logic   w_run;
  logic   w_push;
  logic   w_pop;
  logic   w_full;
  logic   w_empty;
  logic   w_wd_hit;
  logic   w_retire;

  assign w_run    = (r_state == ST_RUN);
  assign w_retire = trace.reg_we | trace.mem_wr | trace.hlt;
  assign w_push   = w_run & ~clear &
                    (trace.reg_we | trace.mem_rd | trace.mem_wr | trace.hlt);
  assign w_pop    = trace.out_valid & trace.out_ready;
  // The expiring cycle is not counted, so a timed-out run reports MAX_CYCLES-1.
  assign w_wd_hit = w_run & ~trace.hlt & (cycle_cnt == c_wd_limit);

  assign trace.out_valid = ~w_empty;
  assign done            = (r_state == ST_HALTED);
  assign timeout         = (r_state == ST_TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (en) w_next = ST_RUN;
      ST_RUN: begin
        if (trace.hlt)     w_next = ST_HALTED;
        else if (w_wd_hit) w_next = ST_TIMEOUT;
      end
      default: w_next = r_state;
    endcase
    if (clear) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (w_run && !w_wd_hit) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (w_run && w_retire)  inst_cnt  <= inst_cnt + CNT_W'(1);
      if (w_push && w_full && !w_pop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear),
    .push  (w_push),
    .pop   (w_pop),
    .din   (pack_rec(trace.hlt, trace.mem_wr, trace.mem_rd, trace.reg_we,
                     trace.reg_dst, trace.pc, trace.reg_data,
                     trace.mem_addr, trace.mem_data)),
    .dout  (trace.out_rec),
    .full  (w_full),
    .empty (w_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_perf_trace_unit.sv
// ============================================================================
// tb_perf_trace_unit : scenario tasks plus randomized run against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_perf_trace_unit;

  localparam int DEPTH      = 8;
  localparam int CNT_W      = 32;
  localparam int MAX_CYCLES = 16;
  localparam int S_IDLE = 0, S_RUN = 1, S_HALTED = 2, S_TIMEOUT = 3;

  logic clk, rst_n, en, clear;
  logic [CNT_W-1:0] cycle_cnt, inst_cnt;
  logic [15:0] drop_cnt;
  logic overflow, done, timeout;
  logic [155:0] dut_vec;

  int vectors = 0;
  int errs    = 0;

  // reference model state
  logic [71:0] mq[$];
  int          m_state;
  logic [31:0] m_cyc, m_inst;
  logic [15:0] m_drop;
  logic        m_ovf;

  perf_trace_unit_if bus();

  perf_trace_unit #(
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clear     (clear),
    .trace     (bus),
    .cycle_cnt (cycle_cnt),
    .inst_cnt  (inst_cnt),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow),
    .done      (done),
    .timeout   (timeout)
  );

  assign dut_vec = {bus.out_valid, bus.out_rec, cycle_cnt, inst_cnt, drop_cnt,
                    overflow, done, timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [155:0] model_vec();
    logic [71:0] head;
    head = (mq.size() > 0) ? mq[0] : 72'h0;
    return {mq.size() > 0, head, m_cyc, m_inst, m_drop, m_ovf,
            m_state == S_HALTED, m_state == S_TIMEOUT};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_state = S_IDLE;
    m_cyc = 0; m_inst = 0; m_drop = 0; m_ovf = 1'b0;
  endtask

  task automatic model_step();
    bit full0, pop, ev, retire;
    if (clear) begin
      model_reset();
      return;
    end
    full0  = (mq.size() == DEPTH);
    pop    = (mq.size() > 0) && bus.out_ready;
    ev     = (m_state == S_RUN) && (bus.reg_we || bus.mem_rd || bus.mem_wr || bus.hlt);
    retire = bus.reg_we || bus.mem_wr || bus.hlt;
    if (pop) void'(mq.pop_front());
    if (ev) begin
      if (!full0 || pop)
        mq.push_back({bus.hlt, bus.mem_wr, bus.mem_rd, bus.reg_we, bus.reg_dst,
                      bus.pc, bus.reg_data, bus.mem_addr, bus.mem_data});
      else begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
    end
    case (m_state)
      S_IDLE: if (en) m_state = S_RUN;
      S_RUN: begin
        if (retire) m_inst = m_inst + 1;
        if (bus.hlt) begin
          m_cyc   = m_cyc + 1;
          m_state = S_HALTED;
        end else if (m_cyc == MAX_CYCLES - 1) m_state = S_TIMEOUT;
        else m_cyc = m_cyc + 1;
      end
      default: ;
    endcase
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    en = 1'b0; clear = 1'b0;
    bus.pc = '0; bus.reg_we = 1'b0; bus.reg_dst = '0; bus.reg_data = '0;
    bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.hlt = 1'b0;
  endtask

  task automatic start_run(input logic ready);
    idle_inputs();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    bus.out_ready = ready;
    en = 1'b1;
    cycle();
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (dut_vec !== model_vec())
      $display("FAIL reset_state: got %h expected %h", dut_vec, model_vec());
    if (dut_vec !== model_vec()) errs++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reg_writes();
    int recs = 0;
    start_run(1'b1);
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid && bus.out_rec[68] && bus.out_rec[67:64] == 4'd2 &&
          bus.out_rec[47:32] == 16'h0005) recs++;
      bus.reg_we = (i < 3); bus.reg_dst = 4'd2; bus.reg_data = 16'h0005;
      bus.pc = 16'(16'h0100 + i);
      cycle();
    end
    idle_inputs();
    vectors++;
    if (recs != 3) begin errs++; $display("FAIL regwr_records: got %0d expected 3", recs); end
    vectors++;
    if (inst_cnt !== 32'd3) begin errs++; $display("FAIL regwr_inst_cnt: got %0d expected 3", inst_cnt); end
    vectors++;
    if (cycle_cnt !== 32'd5) begin errs++; $display("FAIL regwr_cycle_cnt: got %0d expected 5", cycle_cnt); end
    vectors++;
    if (dut_vec !== model_vec()) begin
      errs++; $display("FAIL regwr_model: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_overflow();
    start_run(1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.mem_wr = 1'b1; bus.mem_addr = 16'h0010; bus.mem_data = 16'(i);
      cycle();
    end
    idle_inputs();
    vectors++;
    if (drop_cnt !== 16'd2) begin errs++; $display("FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt); end
    vectors++;
    if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (!(bus.out_valid === 1'b1 && bus.out_rec[70] && bus.out_rec[31:16] == 16'h0010 &&
            bus.out_rec[15:0] == 16'(i))) begin
        errs++;
        $display("FAIL ovf_drain[%0d]: got valid=%b rec=%h expected mem_data %0d", i,
                 bus.out_valid, bus.out_rec, i);
      end
      cycle();
    end
    vectors++;
    if (bus.out_valid !== 1'b0 || overflow !== 1'b1) begin
      errs++; $display("FAIL ovf_after_drain: got valid=%b ovf=%b expected 0/1", bus.out_valid, overflow);
    end
  endtask

  task automatic test_back_to_back();
    start_run(1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.mem_wr = 1'b1; bus.mem_data = 16'(16'h0100 + i);
      cycle();
    end
    bus.mem_data = 16'h0108; bus.out_ready = 1'b1;
    cycle();
    idle_inputs();
    vectors++;
    if (drop_cnt !== 16'd0) begin errs++; $display("FAIL b2b_drop_cnt: got %0d expected 0", drop_cnt); end
    for (int i = 1; i <= 8; i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_rec[15:0] !== 16'(16'h0100 + i)) begin
        errs++;
        $display("FAIL b2b_order[%0d]: got valid=%b data=%h expected %h", i, bus.out_valid,
                 bus.out_rec[15:0], 16'(16'h0100 + i));
      end
      cycle();
    end
    vectors++;
    if (dut_vec !== model_vec()) begin
      errs++; $display("FAIL b2b_model: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_halt();
    start_run(1'b0);
    bus.hlt = 1'b1; bus.mem_rd = 1'b1; bus.mem_addr = 16'h0020;
    cycle();
    idle_inputs();
    vectors++;
    if (done !== 1'b1 || timeout !== 1'b0) begin
      errs++; $display("FAIL halt_done: got done=%b timeout=%b expected 1/0", done, timeout);
    end
    for (int i = 0; i < 3; i++) begin
      bus.reg_we = 1'b1; bus.mem_wr = 1'b1;
      cycle();
    end
    idle_inputs();
    vectors++;
    if (cycle_cnt !== 32'd1 || inst_cnt !== 32'd1) begin
      errs++; $display("FAIL halt_frozen: got cyc=%0d inst=%0d expected 1/1", cycle_cnt, inst_cnt);
    end
    vectors++;
    if (!(bus.out_valid === 1'b1 && bus.out_rec[71] && bus.out_rec[69] && !bus.out_rec[70] &&
          bus.out_rec[31:16] == 16'h0020)) begin
      errs++; $display("FAIL halt_record: got valid=%b rec=%h expected hlt+mem_rd @0020",
                       bus.out_valid, bus.out_rec);
    end
    bus.out_ready = 1'b1;
    cycle();
    vectors++;
    if (bus.out_valid !== 1'b0 || done !== 1'b1) begin
      errs++; $display("FAIL halt_single: got valid=%b done=%b expected 0/1", bus.out_valid, done);
    end
  endtask

  task automatic test_timeout();
    start_run(1'b1);
    repeat (15) cycle();
    vectors++;
    if (timeout !== 1'b0) begin errs++; $display("FAIL wd_early: got %b expected 0", timeout); end
    cycle();
    vectors++;
    if (timeout !== 1'b1 || cycle_cnt !== 32'd15 || done !== 1'b0) begin
      errs++; $display("FAIL wd_expire: got timeout=%b cyc=%0d done=%b expected 1/15/0",
                       timeout, cycle_cnt, done);
    end
    repeat (2) cycle();
    vectors++;
    if (cycle_cnt !== 32'd15) begin errs++; $display("FAIL wd_frozen: got %0d expected 15", cycle_cnt); end
  endtask

  task automatic test_reset_mid();
    start_run(1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.reg_we = 1'b1; bus.reg_data = 16'(i);
      cycle();
    end
    idle_inputs();
    vectors++;
    if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL rst_pre_valid: got %b expected 1", bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (dut_vec !== 156'h0) begin
      errs++; $display("FAIL rst_async: got %h expected all zero", dut_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    vectors++;
    if (dut_vec !== model_vec()) begin
      errs++; $display("FAIL rst_release: got %h expected %h", dut_vec, model_vec());
    end
    en = 1'b1;
    cycle();
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_wr = 1'b1; bus.mem_data = 16'(i);
      cycle();
    end
    clear = 1'b1; en = 1'b1; bus.reg_we = 1'b1; bus.hlt = 1'b1;
    cycle();
    idle_inputs();
    vectors++;
    if (dut_vec !== 156'h0) begin
      errs++; $display("FAIL clear_flush: got %h expected all zero", dut_vec);
    end
  endtask

  task automatic test_random();
    int pct = 50;
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) pct = $urandom_range(10, 90);
      clear         = ($urandom_range(0, 29) == 0);
      en            = ($urandom_range(0, 3) == 0);
      bus.reg_we    = ($urandom_range(0, 99) < 30);
      bus.mem_rd    = ($urandom_range(0, 99) < 20);
      bus.mem_wr    = ($urandom_range(0, 99) < 20);
      bus.hlt       = ($urandom_range(0, 99) < 4);
      bus.reg_dst   = 4'($urandom);
      bus.pc        = 16'($urandom);
      bus.reg_data  = 16'($urandom);
      bus.mem_addr  = 16'($urandom);
      bus.mem_data  = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 99) < pct);
      cycle();
      vectors++;
      if (dut_vec !== model_vec()) begin
        errs++; $display("FAIL rand[%0d]: got %h expected %h", i, dut_vec, model_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_reg_writes();
    test_overflow();
    test_back_to_back();
    test_halt();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

`default_nettype wire
